// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller command path.
// Contents: SDRAM command encodings {cs_n,ras_n,cas_n,we_n}, the one-hot
// arbiter state type and the default auto-refresh period.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MSET = 4'b0000;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_ACT  = 4'b0011;

  // 7.8 us at 100 MHz
  localparam int unsigned REF_PERIOD_DEF = 780;

  typedef enum logic [4:0] {
    INIT  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// SDRAM pin bus driven by the command arbiter.
// Signals: cke, cs_n, ras_n, cas_n, we_n, bank[1:0], addr[12:0].
// Modports: master = arbiter side (drives the pins), slave = SDRAM side.
interface sdram_arbit_if;
  logic        cke;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [1:0]  bank;
  logic [12:0] addr;

  modport master (output cke, cs_n, ras_n, cas_n, we_n, bank, addr);
  modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, bank, addr);
endinterface

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh request generator.
// Ports: sclk, s_rst_n (async active-low), enable (timer runs when high,
// held at 0 otherwise), grant (refresh being granted this edge),
// aref_req (pending refresh request, at most one outstanding).
module sdram_ref_timer #(
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned CNT_W      = 10
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic enable,
  input  logic grant,
  output logic aref_req
);

  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign tc = enable && (cnt == CNT_W'(REF_PERIOD - 1));

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt      <= '0;
      aref_req <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      // Set has priority so a terminal count coinciding with a grant is not lost
      if (tc)
        aref_req <= 1'b1;
      else if (grant)
        aref_req <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter and sequencer.
// Holds the bus for the init sequencer until flag_init_end, then grants it
// to auto-refresh, write or read (priority in that order), always passing
// through one ARBIT NOP cycle between grants.
// Ports: sclk, s_rst_n; per-master cmd/addr(/bank) inputs and end flags;
// wr_req/rd_req requests; aref_req/aref_en/wr_en/rd_en status/grants;
// sdram: pin bus (cke, command pins, bank, addr).
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned REF_PERIOD = REF_PERIOD_DEF,
  parameter int unsigned CNT_W      = 10
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        flag_init_end,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic        flag_aref_end,
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        flag_wr_end,
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank,
  input  logic        flag_rd_end,
  output logic        aref_req,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  sdram_arbit_if.master sdram
);

  state_t      state, next_state;
  logic [3:0]  cmd;
  logic [12:0] addr;
  logic [1:0]  bank;
  logic        aref_grant;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)
      state <= INIT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (flag_init_end) next_state = ARBIT;
      ARBIT: begin
        if (aref_req)    next_state = AREF;
        else if (wr_req) next_state = WRITE;
        else if (rd_req) next_state = READ;
      end
      AREF:    if (flag_aref_end) next_state = ARBIT;
      WRITE:   if (flag_wr_end)   next_state = ARBIT;
      READ:    if (flag_rd_end)   next_state = ARBIT;
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    cmd     = CMD_NOP;
    addr    = '0;
    bank    = '0;
    aref_en = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state)
      INIT: begin
        cmd  = init_cmd;
        addr = init_addr;
      end
      AREF: begin
        cmd     = aref_cmd;
        addr    = aref_addr;
        aref_en = 1'b1;
      end
      WRITE: begin
        cmd   = wr_cmd;
        addr  = wr_addr;
        bank  = wr_bank;
        wr_en = 1'b1;
      end
      READ: begin
        cmd   = rd_cmd;
        addr  = rd_addr;
        bank  = rd_bank;
        rd_en = 1'b1;
      end
      default: ;
    endcase
    // Pins must read NOP while reset is held, even though INIT forwards init_cmd
    if (!s_rst_n)
      cmd = CMD_NOP;
  end

  assign aref_grant = (next_state == AREF) && (state != AREF);

  assign sdram.cke   = s_rst_n;
  assign sdram.cs_n  = cmd[3];
  assign sdram.ras_n = cmd[2];
  assign sdram.cas_n = cmd[1];
  assign sdram.we_n  = cmd[0];
  assign sdram.bank  = bank;
  assign sdram.addr  = addr;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_ref_timer (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .enable   (state != INIT),
    .grant    (aref_grant),
    .aref_req (aref_req)
  );

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed self-checking bench for sdram_arbit.
module tb_sdram_arbit;
  import sdram_pkg::*;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  logic        flag_init_end;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic        flag_aref_end;
  logic        wr_req;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_bank;
  logic        flag_wr_end;
  logic        rd_req;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        flag_rd_end;
  logic        aref_req, aref_en, wr_en, rd_en;
  logic [3:0]  pin_cmd;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ec       = 0;

  sdram_arbit_if bus ();

  sdram_arbit #(.REF_PERIOD(780), .CNT_W(10)) dut (
    .sclk          (sclk),
    .s_rst_n       (s_rst_n),
    .init_cmd      (init_cmd),
    .init_addr     (init_addr),
    .flag_init_end (flag_init_end),
    .aref_cmd      (aref_cmd),
    .aref_addr     (aref_addr),
    .flag_aref_end (flag_aref_end),
    .wr_req        (wr_req),
    .wr_cmd        (wr_cmd),
    .wr_addr       (wr_addr),
    .wr_bank       (wr_bank),
    .flag_wr_end   (flag_wr_end),
    .rd_req        (rd_req),
    .rd_cmd        (rd_cmd),
    .rd_addr       (rd_addr),
    .rd_bank       (rd_bank),
    .flag_rd_end   (flag_rd_end),
    .aref_req      (aref_req),
    .aref_en       (aref_en),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .sdram         (bus.master)
  );

  assign pin_cmd = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, ec);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
    ec++;
  endtask

  task automatic wait_req(input int unsigned bound);
    int unsigned n = 0;
    while (!aref_req && n < bound) begin
      tick();
      n++;
    end
    check("aref_req_timeout", 32'(aref_req), 32'd1);
  endtask

  task automatic check_grants(input string tag, input logic a, input logic w, input logic r);
    check({tag, "_aref_en"}, 32'(aref_en), 32'(a));
    check({tag, "_wr_en"},   32'(wr_en),   32'(w));
    check({tag, "_rd_en"},   32'(rd_en),   32'(r));
  endtask

  task automatic check_nop(input string tag);
    check({tag, "_cmd"},  32'(pin_cmd),   32'(CMD_NOP));
    check({tag, "_addr"}, 32'(bus.addr),  32'd0);
    check({tag, "_bank"}, 32'(bus.bank),  32'd0);
    check_grants(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    s_rst_n = 1'b0;
    init_cmd = CMD_PRE;  init_addr = 13'h0400; flag_init_end = 1'b0;
    aref_cmd = CMD_AREF; aref_addr = 13'h0400; flag_aref_end = 1'b0;
    wr_req = 1'b0; wr_cmd = CMD_WR; wr_addr = 13'h0; wr_bank = 2'd0; flag_wr_end = 1'b0;
    rd_req = 1'b0; rd_cmd = CMD_RD; rd_addr = 13'h0; rd_bank = 2'd0; flag_rd_end = 1'b0;

    // Reset state
    #12;
    check("rst_cke", 32'(bus.cke), 32'd0);
    check("rst_cmd", 32'(pin_cmd), 32'(CMD_NOP));
    check("rst_aref_req", 32'(aref_req), 32'd0);
    check_grants("rst", 1'b0, 1'b0, 1'b0);
    @(posedge sclk);
    #3 s_rst_n = 1'b1;
    #1;
    check("init_cke", 32'(bus.cke), 32'd1);
    check("init_cmd0", 32'(pin_cmd), 32'(CMD_PRE));

    // Init handoff: pins follow init sequencer for 50 cycles
    for (int i = 0; i < 50; i++) begin
      tick();
      init_cmd  = 4'(i);
      init_addr = 13'(i * 37 + 5);
      #1;
      check("init_cmd", 32'(pin_cmd), 32'(i % 16));
      check("init_addr", 32'(bus.addr), 32'(i * 37 + 5));
      check("init_bank", 32'(bus.bank), 32'd0);
    end
    init_cmd = CMD_MSET;
    flag_init_end = 1'b1;
    tick();
    ec = 0;
    check_nop("arbit_after_init");
    check("arbit_aref_req", 32'(aref_req), 32'd0);

    // First refresh request 780 cycles after leaving INIT
    wait_req(2000);
    check("aref_period1", ec, 32'd780);
    tick();
    check_grants("aref1", 1'b1, 1'b0, 1'b0);
    check("aref1_req_clr", 32'(aref_req), 32'd0);
    check("aref1_cmd", 32'(pin_cmd), 32'(CMD_AREF));
    check("aref1_addr", 32'(bus.addr), 32'h0400);
    repeat (3) tick();
    flag_wr_end = 1'b1;
    tick();
    flag_wr_end = 1'b0;
    check("aref1_ignore_wr_end", 32'(aref_en), 32'd1);
    flag_aref_end = 1'b1;
    tick();
    flag_aref_end = 1'b0;
    check_nop("aref1_exit");

    // Second request exactly one period after the first
    wait_req(2000);
    check("aref_period2", ec, 32'd1560);

    // Priority: aref > write > read, with a NOP cycle between grants
    wr_req = 1'b1; rd_req = 1'b1;
    tick();
    check_grants("prio_aref", 1'b1, 1'b0, 1'b0);
    check("prio_req_clr", 32'(aref_req), 32'd0);
    flag_rd_end = 1'b1;
    tick();
    flag_rd_end = 1'b0;
    check("prio_ignore_rd_end", 32'(aref_en), 32'd1);
    flag_aref_end = 1'b1;
    tick();
    flag_aref_end = 1'b0;
    check_nop("prio_nop1");
    tick();
    check_grants("prio_write", 1'b0, 1'b1, 1'b0);

    // Muxing in WRITE
    wr_cmd = CMD_WR; wr_addr = 13'h155; wr_bank = 2'd2;
    #1;
    check("wr_cmd", 32'(pin_cmd), 32'(CMD_WR));
    check("wr_addr", 32'(bus.addr), 32'h155);
    check("wr_bank", 32'(bus.bank), 32'd2);
    rd_cmd = CMD_ACT;
    #1;
    check("wr_cmd_rd_change", 32'(pin_cmd), 32'(CMD_WR));
    rd_cmd = CMD_RD; rd_addr = 13'h0AA; rd_bank = 2'd3;
    flag_wr_end = 1'b1; wr_req = 1'b0;
    tick();
    flag_wr_end = 1'b0;
    check_nop("prio_nop2");
    tick();
    check_grants("prio_read", 1'b0, 1'b0, 1'b1);
    check("rd_cmd", 32'(pin_cmd), 32'(CMD_RD));
    check("rd_addr", 32'(bus.addr), 32'h0AA);
    check("rd_bank", 32'(bus.bank), 32'd3);
    flag_rd_end = 1'b1; rd_req = 1'b0;
    tick();
    flag_rd_end = 1'b0;
    check_nop("read_exit");

    // Refresh pending during a long write (tc at 3120 and 3900)
    wait_req(2000);
    check("aref_period3", ec, 32'd2340);
    tick();
    flag_aref_end = 1'b1;
    tick();
    flag_aref_end = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    tick();
    check_grants("long_wr", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1700; i++) begin
      tick();
      check("long_wr_en", 32'(wr_en), 32'd1);
      check("long_wr_req", 32'(aref_req), 32'(ec >= 3120));
    end
    flag_wr_end = 1'b1; wr_req = 1'b0;
    tick();
    flag_wr_end = 1'b0;
    check_nop("long_wr_exit");
    check("long_wr_req_held", 32'(aref_req), 32'd1);
    tick();
    check_grants("after_wr_aref", 1'b1, 1'b0, 1'b0);
    check("after_wr_req_clr", 32'(aref_req), 32'd0);
    flag_aref_end = 1'b1;
    tick();
    flag_aref_end = 1'b0;
    check_nop("after_wr_nop");
    check("no_queued_req", 32'(aref_req), 32'd0);
    tick();
    check_grants("after_wr_read", 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a read
    tick();
    #3 s_rst_n = 1'b0;
    flag_init_end = 1'b0; rd_req = 1'b0; init_cmd = CMD_PRE;
    #1;
    check_grants("arst", 1'b0, 1'b0, 1'b0);
    check("arst_cmd", 32'(pin_cmd), 32'(CMD_NOP));
    check("arst_cke", 32'(bus.cke), 32'd0);
    check("arst_aref_req", 32'(aref_req), 32'd0);
    repeat (3) @(posedge sclk);
    #3 s_rst_n = 1'b1;
    #1;
    check("arst_release_cmd", 32'(pin_cmd), 32'(CMD_PRE));
    repeat (900) tick();
    check("init_hold_req", 32'(aref_req), 32'd0);
    check("init_hold_cmd", 32'(pin_cmd), 32'(CMD_PRE));
    check_grants("init_hold", 1'b0, 1'b0, 1'b0);
    flag_init_end = 1'b1;
    tick();
    ec = 0;
    check_nop("reinit_arbit");
    wait_req(2000);
    check("aref_after_reinit", ec, 32'd780);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
